// File: rtl/axi_ram_slave.sv
// AXI3 RAM responder: word-addressed 32-bit RAM behind independent read and
// write engines, each handling one outstanding INCR/FIXED burst (WRAP is
// stepped like INCR).
// Optional feature macro: ADDR_CHECK_EN. When defined, bursts whose start
// address lies outside [BASE_ADDR, BASE_ADDR + 4*DEPTH) answer SLVERR: read
// beats return zero data and writes leave the RAM untouched.
module axi_ram_slave #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  // read address channel
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  // read data channel
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // write address channel
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  // write data channel
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response channel
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          DEPTH = 1 << ADDR_W;
  localparam logic [32:0] SPAN  = 33'(1) << (ADDR_W + 2);

`ifdef ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // Word index inside the RAM; upper address bits alias silently.
  function automatic logic [ADDR_W-1:0] word_idx(input logic [31:0] addr);
    return addr[ADDR_W+1:2];
  endfunction

  // Address of the following beat: FIXED holds, INCR/WRAP step by the beat size
  // capped at one 32-bit word.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    logic [31:0] step;
    if (burst == 2'b00)
      step = 32'd0;
    else if (size >= 3'd2)
      step = 32'd4;
    else
      step = 32'd1 << size;
    return addr + step;
  endfunction

  // Start address falls outside the decoded window (only when checking is on).
  function automatic logic addr_bad(input logic [31:0] addr);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, BASE_ADDR};
    return CHECK_EN && (off >= SPAN);
  endfunction

  logic [31:0] mem [DEPTH];

  // Read engine state
  r_state_t    r_state;
  logic [31:0] r_addr;
  logic [31:0] r_addr_nxt;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic        r_err;

  // Write engine state
  w_state_t    w_state;
  logic [31:0] w_addr;
  logic [7:0]  w_len;
  logic [7:0]  w_cnt;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic [3:0]  w_id;
  logic        w_err;
  logic        w_long;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic ar_bad, aw_bad;
  logic mem_we;
  logic unused_ok;

  assign ar_hs      = arvalid & arready;
  assign r_hs       = rvalid & rready;
  assign aw_hs      = awvalid & awready;
  assign w_hs       = wvalid & wready;
  assign b_hs       = bvalid & bready;
  assign ar_bad     = addr_bad(araddr);
  assign aw_bad     = addr_bad(awaddr);
  assign r_addr_nxt = next_addr(r_addr, r_size, r_burst);
  // Out-of-window write bursts still handshake every beat but never touch RAM.
  assign mem_we     = w_hs & ~w_err & aresetn;
  assign unused_ok  = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  // RAM write port with byte enables; contents survive reset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b])
          mem[word_idx(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read burst address/attribute capture and per-beat address stepping.
  always_ff @(posedge aclk) begin
    if (ar_hs) begin
      r_addr  <= araddr;
      r_len   <= arlen;
      r_size  <= arsize;
      r_burst <= arburst;
    end else if (r_hs) begin
      r_addr  <= r_addr_nxt;
    end
  end

  // Read FSM: registered R channel, first beat one cycle after AR, no bubbles.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      rlast   <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rid     <= arid;
            rlast   <= (arlen == 8'd0);
            r_cnt   <= '0;
            r_err   <= ar_bad;
            rresp   <= ar_bad ? RESP_SLVERR : RESP_OKAY;
            rdata   <= ar_bad ? '0 : mem[word_idx(araddr)];
            r_state <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_cnt   <= r_cnt + 8'd1;
              rlast   <= ((r_cnt + 8'd1) == r_len);
              rdata   <= r_err ? '0 : mem[word_idx(r_addr_nxt)];
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write burst address/attribute capture and per-beat address stepping.
  always_ff @(posedge aclk) begin
    if (aw_hs) begin
      w_addr  <= awaddr;
      w_len   <= awlen;
      w_size  <= awsize;
      w_burst <= awburst;
      w_id    <= awid;
      w_err   <= aw_bad;
    end else if (w_hs) begin
      w_addr  <= next_addr(w_addr, w_size, w_burst);
    end
  end

  // Write FSM: accept AW, stream W until wlast, then hold B until accepted.
  // w_long remembers a beat arriving after the announced length was reached,
  // so an 8-bit beat counter wrapping back onto w_len cannot hide the overrun.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
      w_cnt   <= '0;
      w_long  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            awready <= 1'b0;
            wready  <= 1'b1;
            w_cnt   <= '0;
            w_long  <= 1'b0;
            w_state <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (wlast) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= w_id;
              bresp   <= (w_err || w_long || (w_cnt != w_len)) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else begin
              w_cnt   <= w_cnt + 8'd1;
              if (w_cnt == w_len)
                w_long <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (b_hs) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule
